// File: rtl/packbits_pkg.sv
// Shared definitions for the PackBits decoder: FSM states, header constants
// and the header-to-count helper.
package packbits_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LIT,
        S_RUNB,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] NOP_HDR = 8'h80;
    localparam int LIT_MAX = 128;
    localparam int RUN_MAX = 128;
    localparam int HCNT_W = $clog2((LIT_MAX > RUN_MAX) ? LIT_MAX : RUN_MAX) + 1;
    localparam int DEF_NUM_PIXELS = 16384;

    typedef logic [HCNT_W-1:0] hcnt_t;

    // Literal headers carry count-1, run headers carry 1-count in two's complement.
    function automatic hcnt_t hdrCount(input logic [7:0] h);
        logic [7:0] w_lit;
        logic [7:0] w_run;
        w_lit = h + 8'd1;
        w_run = 8'd1 - h;
        return h[7] ? hcnt_t'(w_run) : hcnt_t'(w_lit);
    endfunction

endpackage

// File: rtl/packbits_decoder_if.sv
// Compressed-byte input stream and decoded-pixel output stream of the decoder.
interface packbits_decoder_if;
    logic [7:0] comp_data;
    logic       comp_vld;
    logic       comp_done;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;

    modport master (
        output comp_data, comp_vld, comp_done, pix_ready,
        input  pix_data, pix_valid
    );

    modport slave (
        input  comp_data, comp_vld, comp_done, pix_ready,
        output pix_data, pix_valid
    );
endinterface

// File: rtl/packbits_decoder_byte_fifo.sv
// Synchronous byte FIFO with clear; a write during clear becomes the sole entry.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_doRd;
    logic             w_doWr;
    logic             w_memWr;
    logic [AW-1:0]    w_wrIdx;

    assign o_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doRd     = i_rd && !o_empty;
    assign w_doWr     = i_wr && (!w_full || w_doRd);
    assign o_overflow = i_wr && !i_clr && !w_doWr;
    assign o_rdata    = r_mem[r_rdPtr[AW-1:0]];
    assign w_memWr    = i_clr ? i_wr : w_doWr;
    assign w_wrIdx    = i_clr ? '0 : r_wrPtr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_clr) begin
            r_rdPtr <= '0;
            r_wrPtr <= i_wr ? PTR_ONE : '0;
        end else begin
            if (w_doWr) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_doRd) r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_memWr) r_mem[w_wrIdx] <= i_wdata;
    end
endmodule

// File: rtl/packbits_decoder.sv
// PackBits decoder: expands the compressor's byte stream back into a raster
// pixel stream with a valid/ready output register and sticky error flags.
module packbits_decoder
    import packbits_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    packbits_decoder_if.slave   bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_overflow,
    output logic                o_err_overrun,
    output logic                o_err_underrun
);
    localparam hcnt_t            CNT_ONE = hcnt_t'(1);
    localparam logic [CNT_W-1:0] PIX_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIXELS - 1);

    state_t           r_state, w_next;
    hcnt_t            r_cnt, w_cnt;
    logic [7:0]       r_runByte;
    logic [CNT_W-1:0] r_pixCnt;
    logic [7:0]       r_pixData;
    logic             r_pixValid;
    logic             r_done, r_ended, r_compDone;
    logic             r_errOverflow, r_errOverrun, r_errUnderrun;

    logic [7:0] w_fifoData, w_emitData;
    logic       w_fifoEmpty, w_fifoDrop, w_pop, w_emit, w_latchRun;
    logic       w_setOverrun, w_setUnderrun, w_setEnded, w_doneNext;
    logic       w_outFree, w_last, w_starved, w_extra;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (i_start),
        .i_wr       (bus.comp_vld),
        .i_wdata    (bus.comp_data),
        .i_rd       (w_pop),
        .o_rdata    (w_fifoData),
        .o_empty    (w_fifoEmpty),
        .o_overflow (w_fifoDrop)
    );

    assign w_outFree = !r_pixValid || bus.pix_ready;
    assign w_last    = (r_pixCnt == PIX_LAST);
    assign w_starved = w_fifoEmpty && r_compDone;
    assign w_extra   = r_ended && (!w_fifoEmpty || bus.comp_vld);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_cnt         = r_cnt;
        w_pop         = 1'b0;
        w_emit        = 1'b0;
        w_emitData    = w_fifoData;
        w_latchRun    = 1'b0;
        w_setOverrun  = 1'b0;
        w_setUnderrun = 1'b0;
        w_setEnded    = 1'b0;
        w_doneNext    = 1'b0;
        if (i_start) begin
            w_next = S_HDR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pop        = !w_fifoEmpty;
                    w_setOverrun = w_extra;
                end
                S_HDR: begin
                    if (!w_fifoEmpty) begin
                        w_pop = 1'b1;
                        if (w_fifoData != NOP_HDR) begin
                            w_cnt  = hdrCount(w_fifoData);
                            w_next = w_fifoData[7] ? S_RUNB : S_LIT;
                        end
                    end else if (r_compDone) begin
                        w_setUnderrun = 1'b1;
                        w_next        = S_DONE;
                    end
                end
                S_LIT: begin
                    if (!w_fifoEmpty && w_outFree) begin
                        w_pop  = 1'b1;
                        w_emit = 1'b1;
                        w_cnt  = r_cnt - CNT_ONE;
                        if (w_cnt == '0) w_next = S_HDR;
                    end else if (w_starved) begin
                        w_setUnderrun = 1'b1;
                        w_next        = S_DONE;
                    end
                end
                S_RUNB: begin
                    if (!w_fifoEmpty && w_outFree) begin
                        w_pop      = 1'b1;
                        w_emit     = 1'b1;
                        w_latchRun = 1'b1;
                        w_cnt      = r_cnt - CNT_ONE;
                        w_next     = S_RUN;
                    end else if (w_starved) begin
                        w_setUnderrun = 1'b1;
                        w_next        = S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_outFree) begin
                        w_emit     = 1'b1;
                        w_emitData = r_runByte;
                        w_cnt      = r_cnt - CNT_ONE;
                        if (w_cnt == '0) w_next = S_HDR;
                    end
                end
                S_DONE: begin
                    w_pop        = !w_fifoEmpty;
                    w_setOverrun = w_extra;
                    if (w_outFree) begin
                        w_doneNext = 1'b1;
                        w_next     = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
            // The image ends on its last pixel even if the current code has counts left.
            if (w_emit && w_last) begin
                w_next       = S_DONE;
                w_setEnded   = 1'b1;
                w_setOverrun = (w_cnt != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_runByte     <= '0;
            r_pixCnt      <= '0;
            r_pixData     <= '0;
            r_pixValid    <= 1'b0;
            r_done        <= 1'b0;
            r_ended       <= 1'b0;
            r_compDone    <= 1'b0;
            r_errOverflow <= 1'b0;
            r_errOverrun  <= 1'b0;
            r_errUnderrun <= 1'b0;
        end else if (i_start) begin
            r_cnt         <= '0;
            r_pixCnt      <= '0;
            r_pixValid    <= 1'b0;
            r_done        <= 1'b0;
            r_ended       <= 1'b0;
            r_compDone    <= 1'b0;
            r_errOverflow <= 1'b0;
            r_errOverrun  <= 1'b0;
            r_errUnderrun <= 1'b0;
        end else begin
            r_cnt  <= w_cnt;
            r_done <= w_doneNext;
            if (w_latchRun) r_runByte <= w_fifoData;
            if (w_emit) begin
                r_pixData  <= w_emitData;
                r_pixValid <= 1'b1;
                r_pixCnt   <= r_pixCnt + PIX_ONE;
            end else if (bus.pix_ready) begin
                r_pixValid <= 1'b0;
            end
            if (w_setEnded)    r_ended       <= 1'b1;
            if (bus.comp_done) r_compDone    <= 1'b1;
            if (w_fifoDrop)    r_errOverflow <= 1'b1;
            if (w_setOverrun)  r_errOverrun  <= 1'b1;
            if (w_setUnderrun) r_errUnderrun <= 1'b1;
        end
    end

    assign bus.pix_data   = r_pixData;
    assign bus.pix_valid  = r_pixValid;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_err_overflow = r_errOverflow;
    assign o_err_overrun  = r_errOverrun;
    assign o_err_underrun = r_errUnderrun;
endmodule

// File: tb/tb_packbits_decoder.sv
// Directed bench for packbits_decoder: three instances sized for the
// 4-, 5- and 128-pixel scenarios share one stimulus driver, selected by tbSel.
module tb_packbits_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] tbStart = '0;
    logic [1:0] tbSel = 2'd0;
    logic [7:0] tbData = '0;
    logic       tbVld = 1'b0;
    logic       tbCompDone = 1'b0;
    logic       tbReady = 1'b1;

    logic [7:0] pixData [3];
    logic [2:0] pixValid, busy, done, errOvf, errOvr, errUnd;

    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] gotPix[$];
    int         doneCnt = 0;
    logic       holdEn = 1'b0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData = '0;

    packbits_decoder_if bus0 ();
    packbits_decoder_if bus1 ();
    packbits_decoder_if bus2 ();

    assign bus0.comp_data = tbData;
    assign bus0.comp_vld  = tbVld && (tbSel == 2'd0);
    assign bus0.comp_done = tbCompDone && (tbSel == 2'd0);
    assign bus0.pix_ready = tbReady;
    assign bus1.comp_data = tbData;
    assign bus1.comp_vld  = tbVld && (tbSel == 2'd1);
    assign bus1.comp_done = tbCompDone && (tbSel == 2'd1);
    assign bus1.pix_ready = tbReady;
    assign bus2.comp_data = tbData;
    assign bus2.comp_vld  = tbVld && (tbSel == 2'd2);
    assign bus2.comp_done = tbCompDone && (tbSel == 2'd2);
    assign bus2.pix_ready = tbReady;

    assign pixData[0] = bus0.pix_data;
    assign pixData[1] = bus1.pix_data;
    assign pixData[2] = bus2.pix_data;
    assign pixValid   = {bus2.pix_valid, bus1.pix_valid, bus0.pix_valid};

    packbits_decoder #(.NUM_PIXELS(4), .FIFO_DEPTH(16), .CNT_W(15)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(tbStart[0]), .bus(bus0), .o_busy(busy[0]),
        .o_done(done[0]), .o_err_overflow(errOvf[0]), .o_err_overrun(errOvr[0]),
        .o_err_underrun(errUnd[0]));
    packbits_decoder #(.NUM_PIXELS(5), .FIFO_DEPTH(16), .CNT_W(15)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(tbStart[1]), .bus(bus1), .o_busy(busy[1]),
        .o_done(done[1]), .o_err_overflow(errOvf[1]), .o_err_overrun(errOvr[1]),
        .o_err_underrun(errUnd[1]));
    packbits_decoder #(.NUM_PIXELS(128), .FIFO_DEPTH(16), .CNT_W(15)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(tbStart[2]), .bus(bus2), .o_busy(busy[2]),
        .o_done(done[2]), .o_err_overflow(errOvf[2]), .o_err_overrun(errOvr[2]),
        .o_err_underrun(errUnd[2]));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfers happen at the next posedge, so negedge sampling sees valid/ready for that edge.
    always @(negedge clk) begin
        if (holdEn && prevStall) begin
            checkOutput("holdValid", pixValid[tbSel], 1);
            checkOutput("holdData", pixData[tbSel], prevData);
        end
        prevStall = pixValid[tbSel] && !tbReady;
        prevData  = pixData[tbSel];
        if (pixValid[tbSel] && tbReady) gotPix.push_back(pixData[tbSel]);
        if (done[tbSel]) doneCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tbData = b;
        tbVld  = 1'b1;
        tick();
        tbVld  = 1'b0;
    endtask

    task automatic startDut(input int k);
        tbSel      = 2'(k);
        tbStart[k] = 1'b1;
        tick();
        tbStart = '0;
        gotPix.delete();
        doneCnt = 0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (doneCnt != 0) break;
            @(negedge clk);
        end
        if (doneCnt == 0) checkOutput("doneTimeout", doneCnt, 1);
        repeat (2) tick();
    endtask

    task automatic checkPixels(input string tag, input logic [7:0] exp[$]);
        checkOutput({tag, "Count"}, gotPix.size(), exp.size());
        for (int i = 0; i < exp.size() && i < gotPix.size(); i++)
            checkOutput(tag, gotPix[i], exp[i]);
    endtask

    initial begin
        logic [7:0] exp[$];
        logic [7:0] t3Bytes[6];
        int bad;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("rstFlags", {pixValid[k], done[k], busy[k], errOvf[k], errOvr[k], errUnd[k]}, 0);
            checkOutput("rstData", pixData[k], 0);
        end

        $display("[TB] literal-only image");
        startDut(0);
        checkOutput("litBusy", busy[0], 1);
        applyStimulus(8'h03);
        applyStimulus(8'h0A);
        applyStimulus(8'h0B);
        applyStimulus(8'h0C);
        applyStimulus(8'h0D);
        waitDone(50);
        exp = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        checkPixels("litPix", exp);
        checkOutput("litDone", doneCnt, 1);
        checkOutput("litBusyEnd", busy[0], 0);
        checkOutput("litErrs", {errOvf[0], errOvr[0], errUnd[0]}, 0);

        $display("[TB] run of 128");
        startDut(2);
        applyStimulus(8'h81);
        applyStimulus(8'h55);
        checkOutput("runLatValid0", pixValid[2], 0);
        tick();
        checkOutput("runLatValid1", pixValid[2], 1);
        checkOutput("runLatData", pixData[2], 8'h55);
        waitDone(400);
        checkOutput("runCount", gotPix.size(), 128);
        bad = 0;
        foreach (gotPix[i]) if (gotPix[i] != 8'h55) bad++;
        checkOutput("runBytes", bad, 0);
        checkOutput("runDone", doneCnt, 1);
        checkOutput("runErrs", {errOvf[2], errOvr[2], errUnd[2]}, 0);

        $display("[TB] mixed with no-op and backpressure");
        startDut(1);
        holdEn = 1'b1;
        t3Bytes = '{8'h80, 8'hFE, 8'h11, 8'h01, 8'h22, 8'h33};
        for (int i = 0; i < 80 && doneCnt == 0; i++) begin
            tbReady = (i % 2 == 0);
            if (i < 6) begin
                tbData = t3Bytes[i];
                tbVld  = 1'b1;
            end else begin
                tbVld = 1'b0;
            end
            tick();
        end
        tbVld   = 1'b0;
        tbReady = 1'b1;
        waitDone(50);
        holdEn = 1'b0;
        exp = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h33};
        checkPixels("mixPix", exp);
        checkOutput("mixDone", doneCnt, 1);
        checkOutput("mixErrs", {errOvf[1], errOvr[1], errUnd[1]}, 0);

        $display("[TB] FIFO overflow");
        tbReady = 1'b0;
        startDut(2);
        applyStimulus(8'h7F);
        applyStimulus(8'hA0);
        repeat (3) tick();
        checkOutput("ovfStallValid", pixValid[2], 1);
        checkOutput("ovfStallData", pixData[2], 8'hA0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'hB0 + 8'(i));
            if (i == 15) checkOutput("ovfAt16", errOvf[2], 0);
            if (i == 16) checkOutput("ovfAt17", errOvf[2], 1);
        end
        tbReady = 1'b1;
        repeat (30) tick();
        exp = '{8'hA0};
        for (int i = 0; i < 16; i++) exp.push_back(8'hB0 + 8'(i));
        checkPixels("ovfPix", exp);
        checkOutput("ovfSticky", errOvf[2], 1);

        $display("[TB] overrun");
        startDut(0);
        applyStimulus(8'hFD);
        applyStimulus(8'h77);
        applyStimulus(8'h00);
        applyStimulus(8'h99);
        waitDone(50);
        exp = '{8'h77, 8'h77, 8'h77, 8'h77};
        checkPixels("ovrPix", exp);
        checkOutput("ovrFlag", errOvr[0], 1);
        checkOutput("ovrUnder", errUnd[0], 0);
        checkOutput("ovrDone", doneCnt, 1);

        $display("[TB] underrun");
        startDut(0);
        checkOutput("undClearOvr", errOvr[0], 0);
        applyStimulus(8'h01);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        tbCompDone = 1'b1;
        tick();
        tbCompDone = 1'b0;
        waitDone(50);
        exp = '{8'hAA, 8'hBB};
        checkPixels("undPix", exp);
        checkOutput("undFlag", errUnd[0], 1);
        checkOutput("undOvr", errOvr[0], 0);
        checkOutput("undDone", doneCnt, 1);

        $display("[TB] abort with simultaneous byte");
        tbReady = 1'b0;
        startDut(0);
        applyStimulus(8'h7F);
        applyStimulus(8'h11);
        repeat (2) tick();
        checkOutput("abtPreValid", pixValid[0], 1);
        tbStart[0] = 1'b1;
        tbData     = 8'h03;
        tbVld      = 1'b1;
        tbReady    = 1'b1;
        tick();
        tbStart = '0;
        tbVld   = 1'b0;
        gotPix.delete();
        doneCnt = 0;
        checkOutput("abtValidDrop", pixValid[0], 0);
        checkOutput("abtBusy", busy[0], 1);
        checkOutput("abtErrClear", errUnd[0], 0);
        applyStimulus(8'h0A);
        applyStimulus(8'h0B);
        applyStimulus(8'h0C);
        applyStimulus(8'h0D);
        waitDone(50);
        exp = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        checkPixels("abtPix", exp);
        checkOutput("abtDone", doneCnt, 1);

        $display("[TB] reset mid-image");
        startDut(2);
        applyStimulus(8'h81);
        applyStimulus(8'h55);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gotPix.delete();
        doneCnt = 0;
        checkOutput("midRstFlags", {pixValid[2], busy[2], errOvf[2], errOvr[2], errUnd[2]}, 0);
        repeat (20) tick();
        checkOutput("midRstNoPix", gotPix.size(), 0);
        checkOutput("midRstNoDone", doneCnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
